// File: rtl/sram_pkg.sv
// Shared constants and reader state encoding for the SRAM tile read path.
package sram_pkg;

  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned LENGTH     = 16;
  localparam int unsigned ROW_WIDTH  = DATA_WIDTH * LENGTH;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sram_rd_fifo.sv
// Four-entry synchronous FIFO with a show-ahead head; each entry carries a row
// and its end-of-transfer flag.
module sram_rd_fifo
  import sram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ROW_WIDTH-1:0] wr_data,
  input  logic                 wr_last,
  input  logic                 rd_en,
  output logic [ROW_WIDTH-1:0] rd_data,
  output logic                 rd_last,
  output logic                 empty,
  output logic [2:0]           count
);

  logic [ROW_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                 last_q [FIFO_DEPTH];
  logic [1:0]           wr_ptr_q;
  logic [1:0]           rd_ptr_q;
  logic [2:0]           count_q;

  // Storage is not reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q]  <= wr_data;
      last_q[wr_ptr_q] <= wr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty   = (count_q == 3'd0);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign rd_last = !empty && last_q[rd_ptr_q];

endmodule

// File: rtl/sram_tile_reader.sv
// Streams a run of consecutive SRAM rows onto a valid/ready interface, hiding
// the SRAM's read latency behind a credit-limited four-entry FIFO.
module sram_tile_reader
  import sram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_rows,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [ROW_WIDTH-1:0]  rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ROW_WIDTH-1:0]  m_data,
  output logic                  m_last
);

  rd_state_e             state_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [ADDR_WIDTH:0]   nrows_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic                  pend1_q, pend2_q;
  logic                  last1_q, last2_q;
  logic [1:0]            inflight_q;
  logic                  busy_q, done_q;

  logic [2:0]            fifo_count;
  logic                  fifo_empty;
  logic                  pop;
  logic [3:0]            occupancy;
  logic                  credit_ok;
  logic                  issue_d;
  logic [ADDR_WIDTH:0]   issued_inc;
  logic                  last_issue;

  assign pop        = m_valid && m_ready;
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign credit_ok  = (occupancy < 4'(FIFO_DEPTH));
  assign issued_inc = issued_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign last_issue = (issued_inc == nrows_q);
  assign issue_d    = ((state_q == IDLE) && start && (num_rows != '0)) ||
                      ((state_q == ISSUE) && credit_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      raddr_q    <= '0;
      nrows_q    <= '0;
      issued_q   <= '0;
      pend1_q    <= 1'b0;
      pend2_q    <= 1'b0;
      last1_q    <= 1'b0;
      last2_q    <= 1'b0;
      inflight_q <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Two-stage read pipeline: address cycle, then SRAM output cycle.
      pend1_q    <= 1'b0;
      last1_q    <= 1'b0;
      pend2_q    <= pend1_q;
      last2_q    <= last1_q;
      inflight_q <= inflight_q + {1'b0, issue_d} - {1'b0, pend2_q};
      case (state_q)
        IDLE: begin
          if (start) begin
            nrows_q <= num_rows;
            busy_q  <= 1'b1;
            if (num_rows == '0) begin
              state_q <= DRAIN;
              done_q  <= 1'b1;
            end else begin
              raddr_q  <= base_addr;
              pend1_q  <= 1'b1;
              last1_q  <= (num_rows == {{ADDR_WIDTH{1'b0}}, 1'b1});
              issued_q <= {{ADDR_WIDTH{1'b0}}, 1'b1};
              state_q  <= (num_rows == {{ADDR_WIDTH{1'b0}}, 1'b1}) ? DRAIN : ISSUE;
            end
          end
        end
        ISSUE: begin
          if (credit_ok) begin
            raddr_q  <= raddr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            pend1_q  <= 1'b1;
            last1_q  <= last_issue;
            issued_q <= issued_inc;
            if (last_issue) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (pop && (fifo_count == 3'd1) && (inflight_q == 2'd0)) begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sram_rd_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pend2_q),
    .wr_data (rdata),
    .wr_last (last2_q),
    .rd_en   (pop),
    .rd_data (m_data),
    .rd_last (m_last),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign busy    = busy_q;
  assign done    = done_q;
  assign raddr   = raddr_q;

endmodule
